// File: rtl/jpeg_pkg.sv
// Shared JPEG coefficient-path definitions: default widths, buffer bank states
// and the zig-zag scan position -> raster (row*8+col) index table.
package jpeg_pkg;

  localparam int WIDTH_IN_DEF  = 16;
  localparam int WIDTH_Q_DEF   = 16;
  localparam int WIDTH_OUT_DEF = 32;
  localparam int NUM_QT_DEF    = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  localparam logic [5:0] ZZ2RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] zz2raster(input logic [5:0] k);
    return ZZ2RASTER[k];
  endfunction

endpackage

// File: rtl/jpeg_coef_pingpong.sv
// Two-bank 64-entry coefficient buffer; a bank turns FULL on its last write and is
// read out in raster order, output valid the cycle after FULL; writes stall while the write bank is FULL.
module jpeg_coef_pingpong
  import jpeg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [5:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_done,
  output logic             wr_ok,
  input  logic             rd_en,
  output logic             rd_ok,
  output logic [WIDTH-1:0] rd_data,
  output logic [5:0]       rd_idx,
  output logic             rd_last
);

  logic [WIDTH-1:0] mem [2][64];
  bank_state_t      state_q [2];
  bank_state_t      state_d [2];
  logic             wr_bank;
  logic             rd_bank;
  logic [5:0]       rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_ok   = (state_q[wr_bank] != BANK_FULL);
  assign rd_ok   = (state_q[rd_bank] == BANK_FULL);
  assign wr_fire = wr_en && wr_ok;
  assign rd_fire = rd_en && rd_ok;
  assign rd_last = (rd_ptr == 6'd63);
  assign rd_idx  = rd_ptr;
  assign rd_data = rd_ok ? mem[rd_bank][rd_ptr] : '0;

  // A FULL read bank and a non-FULL write bank are never the same bank.
  always_comb begin
    state_d = state_q;
    if (wr_fire) state_d[wr_bank] = wr_done ? BANK_FULL : BANK_FILLING;
    if (rd_fire && rd_last) state_d[rd_bank] = BANK_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '{BANK_EMPTY, BANK_EMPTY};
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_fire && wr_done) wr_bank <= ~wr_bank;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 6'd1;
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_addr] <= wr_data;
  end

endmodule

// File: rtl/jpeg_dequant_zigzag_stream.sv
// Dequantises zig-zag coefficients and reorders them to raster; out_valid 1 cycle after a block's
// 64th accept, 1 coef/cycle sustained; in_ready drops only when both ping-pong banks hold unread blocks.
module jpeg_dequant_zigzag_stream
  import jpeg_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_IN_DEF,
  parameter int WIDTH_Q   = WIDTH_Q_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int NUM_QT    = NUM_QT_DEF,
  localparam int QSW      = (NUM_QT > 1) ? $clog2(NUM_QT) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_coef,
  input  logic [QSW-1:0]              in_qt_sel,
  input  logic                        in_bypass,
  input  logic                        qt_wr_en,
  input  logic [QSW-1:0]              qt_wr_sel,
  input  logic [5:0]                  qt_wr_addr,
  input  logic [WIDTH_Q-1:0]          qt_wr_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_coef,
  output logic [5:0]                  out_idx,
  output logic                        out_last
);

  localparam int PW = WIDTH_IN + WIDTH_Q + 1;

  logic [WIDTH_Q-1:0]          qt [NUM_QT][64];
  logic [5:0]                  count;
  logic [QSW-1:0]              sel_q;
  logic                        byp_q;
  logic                        live_q;
  logic                        wr_ok;
  logic                        accept;
  logic [QSW-1:0]              sel_eff;
  logic                        byp_eff;
  logic [WIDTH_Q-1:0]          q_entry;
  logic signed [PW-1:0]        prod;
  logic signed [WIDTH_OUT-1:0] prod_sat;
  logic [5:0]                  wr_addr;

  assign in_ready = live_q && wr_ok;
  assign accept   = in_valid && in_ready;
  // Block-wide selectors come straight from the ports on the first coefficient.
  assign sel_eff  = (count == 6'd0) ? in_qt_sel : sel_q;
  assign byp_eff  = (count == 6'd0) ? in_bypass : byp_q;
  assign q_entry  = qt[sel_eff][count];
  assign prod     = in_coef * $signed({1'b0, q_entry});
  assign wr_addr  = byp_eff ? count : zz2raster(count);

  generate
    if (WIDTH_OUT < PW) begin : g_sat
      localparam logic signed [PW-1:0] MAX_V = {{(PW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
      localparam logic signed [PW-1:0] MIN_V = {{(PW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
      always_comb begin
        prod_sat = prod[WIDTH_OUT-1:0];
        if (prod > MAX_V)      prod_sat = MAX_V[WIDTH_OUT-1:0];
        else if (prod < MIN_V) prod_sat = MIN_V[WIDTH_OUT-1:0];
      end
    end else begin : g_ext
      assign prod_sat = WIDTH_OUT'(prod);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      count  <= '0;
      sel_q  <= '0;
      byp_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        count <= count + 6'd1;
        if (count == 6'd0) begin
          sel_q <= in_qt_sel;
          byp_q <= in_bypass;
        end
      end
    end
  end

  // Table writes land at the clock edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_QT; s++)
        for (int a = 0; a < 64; a++)
          qt[s][a] <= WIDTH_Q'(1);
    end else if (qt_wr_en) begin
      qt[qt_wr_sel][qt_wr_addr] <= qt_wr_data;
    end
  end

  jpeg_coef_pingpong #(.WIDTH(WIDTH_OUT)) u_pingpong (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (prod_sat),
    .wr_done (count == 6'd63),
    .wr_ok   (wr_ok),
    .rd_en   (out_ready),
    .rd_ok   (out_valid),
    .rd_data (out_coef),
    .rd_idx  (out_idx),
    .rd_last (out_last)
  );

endmodule

// File: tb/tb_jpeg_dequant_zigzag_stream.sv
// Randomised scoreboard bench: a block-level reference model predicts raster-ordered outputs.
module tb_jpeg_dequant_zigzag_stream;

  localparam int WI = 16, WQ = 16, WO = 16, NQ = 4, QS = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, in_bypass = 1'b0;
  logic [WI-1:0] in_coef = '0;
  logic [QS-1:0] in_qt_sel = '0, qt_wr_sel = '0;
  logic          qt_wr_en = 1'b0;
  logic [5:0]    qt_wr_addr = '0;
  logic [WQ-1:0] qt_wr_data = '0;
  logic          out_valid, out_ready = 1'b0, out_last;
  logic [WO-1:0] out_coef;
  logic [5:0]    out_idx;

  jpeg_dequant_zigzag_stream #(.WIDTH_IN(WI), .WIDTH_Q(WQ), .WIDTH_OUT(WO), .NUM_QT(NQ)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .in_qt_sel(in_qt_sel), .in_bypass(in_bypass), .qt_wr_en(qt_wr_en), .qt_wr_sel(qt_wr_sel),
    .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int     n_vec = 0, n_err = 0, ready_mode = 0;
  longint cyc = 0;
  int     zz [64];
  longint qtm [NQ][64];
  int     m_cnt, m_sel;
  bit     m_byp;
  longint blk [64];
  typedef struct { int idx; longint coef; } exp_t;
  exp_t   expq [$];
  int     st_n = 0;
  longint st_first = 0, st_last = 0, acc_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint satf(input longint p);
    longint hi = (longint'(1) <<< (WO - 1)) - 1;
    longint lo = -(longint'(1) <<< (WO - 1));
    return (p > hi) ? hi : (p < lo) ? lo : p;
  endfunction

  // Zig-zag scan built by walking anti-diagonals of the 8x8 block.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int rmin = (s > 7) ? s - 7 : 0;
      int rmax = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = rmax; r >= rmin; r--) begin zz[k] = r * 8 + (s - r); k++; end
      else            for (int r = rmin; r <= rmax; r++) begin zz[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_sel = 0; m_byp = 1'b0;
    for (int s = 0; s < NQ; s++) for (int a = 0; a < 64; a++) qtm[s][a] = 1;
    expq.delete();
  endfunction

  function automatic void model_accept(input int coef, input int sel, input bit byp);
    if (m_cnt == 0) begin m_sel = sel; m_byp = byp; end
    blk[m_byp ? m_cnt : zz[m_cnt]] = satf(longint'(coef) * qtm[m_sel][m_cnt]);
    m_cnt++;
    if (m_cnt == 64) begin
      for (int i = 0; i < 64; i++) expq.push_back('{idx: i, coef: blk[i]});
      m_cnt = 0;
    end
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; qt_wr_en = 1'b0; end
  endtask

  task automatic qt_write(input int sel, input int addr, input longint val);
    @(negedge clk);
    in_valid = 1'b0; qt_wr_en = 1'b1;
    qt_wr_sel = sel[QS-1:0]; qt_wr_addr = addr[5:0]; qt_wr_data = val[WQ-1:0];
    qtm[sel][addr] = val;
  endtask

  task automatic fill_table(input int sel, input longint val);
    for (int a = 0; a < 64; a++) qt_write(sel, a, val);
  endtask

  task automatic send(input int coef, input int sel, input bit byp, input bit wr, input longint wv);
    int w = 0;
    int ws = (m_cnt == 0) ? sel : m_sel;
    int wa = m_cnt;
    @(negedge clk);
    qt_wr_en = 1'b0; in_valid = 1'b1;
    in_coef = coef[WI-1:0]; in_qt_sel = sel[QS-1:0]; in_bypass = byp;
    if (wr) begin qt_wr_en = 1'b1; qt_wr_sel = ws[QS-1:0]; qt_wr_addr = wa[5:0]; qt_wr_data = wv[WQ-1:0]; end
    while (!in_ready && w < 3000) begin @(negedge clk); qt_wr_en = 1'b0; w++; end
    if (in_ready) begin
      if (m_cnt == 63) acc_cyc = cyc;
      model_accept(coef, sel, byp);
      if (wr) qtm[ws][wa] = wv;
    end else begin
      check("in_ready_timeout", longint'(in_ready), 1);
      in_valid = 1'b0;
    end
  endtask

  // mode 0: coef = i, 1: constant, 2: random, 3: alternate val / ~val
  task automatic send_block(input int mode, input int val, input int sel, input bit byp);
    for (int i = 0; i < 64; i++) begin
      int c = (mode == 0) ? i : (mode == 1) ? val : (mode == 2) ? rnd_coef() : ((i % 2 == 0) ? val : ~val);
      send(c, sel, byp, 1'b0, 0);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (expq.size() != 0 && w < 5000) begin @(negedge clk); in_valid = 1'b0; qt_wr_en = 1'b0; w++; end
    check("drain_outstanding", longint'(expq.size()), 0);
    idle(2);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: scoreboard pops plus hold-while-stalled checks.
  initial begin
    logic          stall;
    logic [WO-1:0] sc;
    logic [5:0]    si;
    logic          sl;
    exp_t          e;
    stall = 1'b0; sc = '0; si = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall && out_valid) check("stall_hold", longint'({out_coef, out_idx, out_last}), longint'({sc, si, sl}));
        if (out_valid && out_ready) begin
          if (expq.size() == 0) check("unexpected_output", longint'(out_valid), 0);
          else begin
            e = expq.pop_front();
            check("out_idx", longint'(out_idx), e.idx);
            check($sformatf("out_coef[%0d]", e.idx), longint'($signed(out_coef)), e.coef);
            check("out_last", longint'(out_last), longint'(e.idx == 63));
            if (st_n == 0) st_first = cyc;
            st_last = cyc;
            st_n++;
          end
        end
        stall = out_valid && !out_ready;
        sc = out_coef; si = out_idx; sl = out_last;
      end
    end
  end

  initial begin
    longint a64;
    int     acc;
    build_zz();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_coef", longint'(out_coef), 0);
    check("rst_out_idx", longint'(out_idx), 0);
    check("rst_out_last", longint'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", longint'(in_ready), 1);

    ready_mode = 0;
    send_block(0, 0, 0, 1'b0); drain();

    fill_table(0, 5); send_block(1, 10, 0, 1'b0);
    fill_table(2, 7); send_block(1, -3, 2, 1'b0); drain();

    fill_table(3, 65535); send_block(3, -2048, 3, 1'b0); drain();

    fill_table(1, 3); fill_table(0, 1);
    send_block(2, 0, 1, 1'b0); send_block(0, 0, 0, 1'b1); drain();

    // Table entry 5 rewritten while its own coefficient is accepted.
    for (int i = 0; i < 64; i++) send(rnd_coef(), 1, 1'b0, i == 5, 9);
    send_block(2, 0, 1, 1'b0); drain();

    st_n = 0;
    send_block(2, 0, int'($urandom_range(0, 3)), 1'b0); a64 = acc_cyc;
    send_block(2, 0, int'($urandom_range(0, 3)), 1'b0);
    send_block(2, 0, int'($urandom_range(0, 3)), 1'b0);
    drain();
    check("stream_outputs", longint'(st_n), 192);
    check("stream_span", st_last - st_first, 191);
    check("first_out_latency", st_first - a64, 1);

    ready_mode = 1; idle(2);
    acc = 0;
    repeat (150) begin
      int c = rnd_coef();
      @(negedge clk);
      qt_wr_en = 1'b0; in_valid = 1'b1; in_coef = c[WI-1:0]; in_qt_sel = '0; in_bypass = 1'b0;
      if (in_ready) begin model_accept(c, 0, 1'b0); acc++; end
    end
    check("accepts_before_stall", longint'(acc), 128);
    check("in_ready_stalled", longint'(in_ready), 0);
    @(negedge clk); in_valid = 1'b0; ready_mode = 0;
    drain();

    ready_mode = 2;
    repeat (4) begin
      repeat (int'($urandom_range(1, 6)))
        qt_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), longint'($urandom_range(0, 40)));
      send_block(2, 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 4)));
    end
    ready_mode = 0; drain();

    ready_mode = 1;
    fill_table(2, 4);
    send_block(2, 0, 2, 1'b0);
    for (int i = 0; i < 30; i++) send(rnd_coef(), 2, 1'b0, 1'b0, 0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0; model_reset();
    @(negedge clk);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    rst_n = 1'b1; ready_mode = 0;
    @(negedge clk);
    check("in_ready_after_mid_rst", longint'(in_ready), 1);
    repeat (4) begin @(negedge clk); check("no_output_after_rst", longint'(out_valid), 0); end
    send_block(2, 0, 2, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
